vga_sprite_compositor: RTL and testbench

- Parametrised successor to the fixed five-alien/eight-missile VGA top-level compositor.
- Sits between the dtg/sprite generators and the VGA pins.
- Merges N alien layers, M missile layers, the player layer, the background and the win/lose screens into one registered pixel stream.
- Owns the per-alien alive registers, missile-hit detection, score counter and a frame-synchronised game-state machine (PLAY/WIN/LOSE).

---
 rtl/vga_sprite_compositor.sv | 141 ++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// Sprite/background compositor with alive bitmap, hit detection, score
// and a frame-synchronised PLAY/WIN/LOSE game-state machine.
module vga_sprite_compositor #(
  parameter int N_ALIENS     = 5,
  parameter int N_MISSILES   = 8,
  parameter int PIX_W        = 4,
  parameter int SCORE_W      = 8,
  parameter int PTS_PER_KILL = 1
) (
  input  logic                  vga_clk_i,
  input  logic                  vga_rst_i,
  input  logic                  video_on_i,
  input  logic                  frame_start_i,
  input  logic [N_ALIENS-1:0]   alien_active_i,
  input  logic [PIX_W-1:0]      alien_pix_i,
  input  logic [N_MISSILES-1:0] missile_active_i,
  input  logic [PIX_W-1:0]      missile_pix_i,
  input  logic                  player_active_i,
  input  logic [PIX_W-1:0]      player_pix_i,
  input  logic [PIX_W-1:0]      bg_pix_i,
  input  logic [PIX_W-1:0]      win_pix_i,
  input  logic [PIX_W-1:0]      lose_pix_i,
  input  logic                  landed_i,
  input  logic                  restart_i,
  output logic [PIX_W-1:0]      vga_r,
  output logic [PIX_W-1:0]      vga_g,
  output logic [PIX_W-1:0]      vga_b,
  output logic [N_ALIENS-1:0]   alien_alive_o,
  output logic [N_MISSILES-1:0] missile_hit_o,
  output logic [1:0]            game_state_o,
  output logic [SCORE_W-1:0]    score_o
);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } state_e;

  localparam int SUM_W = SCORE_W + 6;
  localparam logic [SUM_W-1:0] SCORE_MAX = {6'b0, {SCORE_W{1'b1}}};

  state_e                state_q, state_d;
  logic [N_ALIENS-1:0]   alive_q, alive_d, kill;
  logic [N_MISSILES-1:0] hit_q, hit_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [PIX_W-1:0]      pix_q, pix_d, mux;
  logic                  land_q, land_d;
  logic                  rstp_q, rstp_d;
  logic                  hit_any, reload;
  logic [SUM_W-1:0]      nkill, sum;

  always_comb begin
    hit_any = video_on_i & (state_q == PLAY) & (|missile_active_i);
    kill    = alien_active_i & alive_q & {N_ALIENS{hit_any}};
    nkill   = '0;
    for (int i = 0; i < N_ALIENS; i++) begin
      nkill = nkill + SUM_W'(kill[i]);
    end
    sum = SUM_W'(score_q) + nkill * SUM_W'(PTS_PER_KILL);
  end

  // Pending restart outranks the win check so a new game always starts clean.
  always_comb begin
    state_d = state_q;
    reload  = 1'b0;
    if (frame_start_i) begin
      if (rstp_q) begin
        state_d = PLAY;
        reload  = 1'b1;
      end else if (state_q == PLAY) begin
        if (alive_q == '0) begin
          state_d = WIN;
        end else if (land_q) begin
          state_d = LOSE;
        end
      end
    end
  end

  always_comb begin
    land_d  = (land_q & ~frame_start_i) | (landed_i & (state_q == PLAY));
    rstp_d  = (rstp_q & ~frame_start_i) | restart_i;
    alive_d = reload ? '1 : (alive_q & ~kill);
    hit_d   = missile_active_i & {N_MISSILES{|kill}};
    if (reload) begin
      score_d = '0;
    end else if (sum > SCORE_MAX) begin
      score_d = {SCORE_W{1'b1}};
    end else begin
      score_d = sum[SCORE_W-1:0];
    end
  end

  always_comb begin
    mux = bg_pix_i;
    case (state_q)
      WIN:  mux = win_pix_i;
      LOSE: mux = lose_pix_i;
      default: begin
        if (|(alien_active_i & alive_q)) begin
          mux = alien_pix_i;
        end else if (|missile_active_i) begin
          mux = missile_pix_i;
        end else if (player_active_i) begin
          mux = player_pix_i;
        end
      end
    endcase
    pix_d = video_on_i ? mux : '0;
  end

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) begin
      state_q <= PLAY;
      alive_q <= '1;
      hit_q   <= '0;
      score_q <= '0;
      pix_q   <= '0;
      land_q  <= 1'b0;
      rstp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      pix_q   <= pix_d;
      land_q  <= land_d;
      rstp_q  <= rstp_d;
    end
  end

  assign vga_r         = pix_q;
  assign vga_g         = pix_q;
  assign vga_b         = pix_q;
  assign alien_alive_o = alive_q;
  assign missile_hit_o = hit_q;
  assign game_state_o  = state_q;
  assign score_o       = score_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Randomised and directed bench for vga_sprite_compositor against a
// behavioural game model; a second instance checks score saturation.
module tb_vga_sprite_compositor;

  logic       clk = 1'b0;
  logic       rst, von, fs;
  logic [4:0] aa;
  logic [7:0] mis;
  logic [3:0] apix, mpix, ppix, bg, wpix, lpix;
  logic       pa, landed, restart;

  logic [3:0] r, g, b, r2, g2, b2;
  logic [4:0] alive, alive2;
  logic [7:0] hit, hit2;
  logic [1:0] gs, gs2;
  logic [7:0] score;
  logic [1:0] score2;

  int n_cmp = 0;
  int n_bad = 0;

  int  m_state;
  bit  m_alive[5];
  int  m_raw;
  bit  m_land, m_rstp;
  int  e_pix;
  int  e_hit;

  always #5 clk = ~clk;

  vga_sprite_compositor dut (
    .vga_clk_i(clk), .vga_rst_i(rst), .video_on_i(von),
    .frame_start_i(fs), .alien_active_i(aa), .alien_pix_i(apix),
    .missile_active_i(mis), .missile_pix_i(mpix),
    .player_active_i(pa), .player_pix_i(ppix), .bg_pix_i(bg),
    .win_pix_i(wpix), .lose_pix_i(lpix), .landed_i(landed),
    .restart_i(restart), .vga_r(r), .vga_g(g), .vga_b(b),
    .alien_alive_o(alive), .missile_hit_o(hit),
    .game_state_o(gs), .score_o(score)
  );

  vga_sprite_compositor #(.SCORE_W(2)) dut_sat (
    .vga_clk_i(clk), .vga_rst_i(rst), .video_on_i(von),
    .frame_start_i(fs), .alien_active_i(aa), .alien_pix_i(apix),
    .missile_active_i(mis), .missile_pix_i(mpix),
    .player_active_i(pa), .player_pix_i(ppix), .bg_pix_i(bg),
    .win_pix_i(wpix), .lose_pix_i(lpix), .landed_i(landed),
    .restart_i(restart), .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .alien_alive_o(alive2), .missile_hit_o(hit2),
    .game_state_o(gs2), .score_o(score2)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int alive_word();
    int w = 0;
    for (int i = 0; i < 5; i++) if (m_alive[i]) w += (1 << i);
    return w;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Advance the game model by one pixel using the inputs currently applied.
  task automatic model_step();
    int  nk, live_cnt, pix, pre_state;
    bit  hit_any, any_alien;
    if (rst) begin
      m_state = 0; m_raw = 0; m_land = 0; m_rstp = 0;
      foreach (m_alive[i]) m_alive[i] = 1;
      e_pix = 0; e_hit = 0;
      return;
    end
    pre_state = m_state;
    live_cnt  = 0;
    foreach (m_alive[i]) live_cnt += m_alive[i];
    hit_any   = von && m_state == 0 && mis != 0;
    nk = 0; any_alien = 0;
    for (int i = 0; i < 5; i++) begin
      if (aa[i] && m_alive[i]) begin
        any_alien = 1;
        if (hit_any) begin
          nk++;
          m_alive[i] = 0;
        end
      end
    end
    if (m_state == 1) pix = wpix;
    else if (m_state == 2) pix = lpix;
    else if (any_alien) pix = apix;
    else if (mis != 0) pix = mpix;
    else if (pa) pix = ppix;
    else pix = bg;
    e_pix = von ? pix : 0;
    e_hit = (nk > 0) ? int'(mis) : 0;
    m_raw += nk;
    if (fs) begin
      if (m_rstp) begin
        m_state = 0; m_raw = 0;
        foreach (m_alive[i]) m_alive[i] = 1;
      end else if (pre_state == 0 && live_cnt == 0) m_state = 1;
      else if (pre_state == 0 && m_land) m_state = 2;
    end
    m_land = (fs ? 1'b0 : m_land) | (landed && pre_state == 0);
    m_rstp = (fs ? 1'b0 : m_rstp) | restart;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("vga_r", r, e_pix);
    chk("vga_g", g, e_pix);
    chk("vga_b", b, e_pix);
    chk("alive", alive, alive_word());
    chk("hit", hit, e_hit);
    chk("state", gs, m_state);
    chk("score", score, sat(m_raw, 255));
    chk("sat_score", score2, sat(m_raw, 3));
    chk("sat_state", gs2, m_state);
    chk("sat_alive", alive2, alive_word());
  endtask

  task automatic clr();
    rst = 0; fs = 0; aa = 0; mis = 0; pa = 0;
    landed = 0; restart = 0; von = 1;
    apix = 4'hA; mpix = 4'hB; ppix = 4'hC; bg = 4'h3;
    wpix = 4'h9; lpix = 4'h6;
  endtask

  task automatic do_reset();
    clr(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    clr();
    do_reset();
    chk("lit_rst_pix", r, 0);
    chk("lit_rst_alive", alive, 5'h1f);
    chk("lit_rst_state", gs, 0);
    chk("lit_rst_score", score, 0);
    tick();
    chk("lit_bg", r, 4'h3);
    von = 0; tick();
    chk("lit_blank", r, 0);
    von = 1;

    aa = 5'b00100; mis = 8'h01; tick();
    chk("lit_kill_alive", alive, 5'b11011);
    chk("lit_kill_hit", hit, 8'h01);
    chk("lit_kill_score", score, 1);
    chk("lit_kill_pix", r, 4'hA);
    aa = 0; mis = 0; tick();
    chk("lit_hit_pulse", hit, 0);
    aa = 5'b00100; tick();
    chk("lit_dead_bg", r, 4'h3);
    mis = 8'h01; tick();
    chk("lit_dead_nohit", hit, 0);
    chk("lit_dead_score", score, 1);

    do_reset();
    aa = 5'b00011; mis = 8'h03; tick();
    chk("lit_dbl_alive", alive, 5'b11100);
    chk("lit_dbl_hit", hit, 8'h03);
    chk("lit_dbl_score", score, 2);

    do_reset();
    aa = 5'h1f; mis = 8'h01; tick();
    chk("lit_all_alive", alive, 0);
    chk("lit_all_score", score, 5);
    chk("lit_all_sat", score2, 3);
    chk("lit_all_play", gs, 0);
    clr(); landed = 1; tick();
    clr(); fs = 1; tick();
    chk("lit_win", gs, 2'b01);
    clr(); tick();
    chk("lit_win_pix", r, 4'h9);
    restart = 1; tick();
    clr(); fs = 1; tick();
    chk("lit_restart_state", gs, 0);
    chk("lit_restart_alive", alive, 5'h1f);
    chk("lit_restart_score", score, 0);

    landed = 1; fs = 0; tick();
    clr(); fs = 1; tick();
    chk("lit_lose", gs, 2'b10);
    clr(); tick();
    chk("lit_lose_pix", r, 4'h6);
    aa = 5'b00001; mis = 8'h01; tick();
    chk("lit_lose_nohit", hit, 0);
    chk("lit_lose_alive", alive, 5'h1f);
    clr(); restart = 1; tick();
    clr(); fs = 1; tick();
    chk("lit_lose_restart", gs, 0);

    clr(); aa = 5'b00001; mis = 8'h01; tick();
    chk("lit_pre_rst_score", score, 1);
    rst = 1; tick();
    chk("lit_midrst_pix", r, 0);
    chk("lit_midrst_alive", alive, 5'h1f);
    chk("lit_midrst_hit", hit, 0);
    chk("lit_midrst_score", score, 0);
    rst = 0;

    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 499) == 0);
      fs      = (c % 50 == 0);
      von     = (c % 50) < 40;
      for (int i = 0; i < 5; i++) aa[i] = ($urandom_range(0, 3) == 0);
      mis     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      pa      = $urandom_range(0, 1);
      landed  = ($urandom_range(0, 149) == 0);
      restart = ($urandom_range(0, 79) == 0);
      apix = 4'($urandom); mpix = 4'($urandom); ppix = 4'($urandom);
      bg   = 4'($urandom); wpix = 4'($urandom); lpix = 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
